// File: rtl/tqvp_irq_arbiter.sv
// ---------------------------------------------------------------------------
// tqvp_irq_arbiter
//
// Interrupt arbiter living in one 64-byte TinyQV user-peripheral slot.
// Collects the user peripheral interrupt lines, latches them as edge- or
// level-sensitive pending requests, picks the lowest-index enabled pending
// source and presents a single registered interrupt to the core. The core
// claims an interrupt by reading CLAIM and completes it by writing the same
// ID back to CLAIM.
//
// Register map (byte address, zero-extended to 32 bits on read):
//   0x00 ENABLE  RW  bit i enables source i
//   0x04 PENDING R   write-1-to-clear, edge-mode sources only
//   0x08 MODE    RW  bit i: 1 = rising edge, 0 = level
//   0x0C CLAIM   read = claim ID, write = completion
//   0x10 STATUS  R   bit 8 = ACTIVE, bits [4:0] = in-service ID
//
// Ports:
//   clk           clock
//   rst_n         synchronous active-low reset
//   irq_in        raw interrupt lines, synchronous to clk (source i = user irq i+2)
//   address       register byte address within the slot
//   data_in       write data
//   data_write_n  11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_read_n   11 none, 00 8-bit, 01 16-bit, 10 32-bit
//   data_out      registered read data, held until the next read
//   data_ready    one-cycle pulse, read data valid
//   irq_out       registered interrupt request to the core
// ---------------------------------------------------------------------------
module tqvp_irq_arbiter #(
  parameter int N_SRC = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [5:0]       address,
  input  logic [31:0]      data_in,
  input  logic [1:0]       data_write_n,
  input  logic [1:0]       data_read_n,
  output logic [31:0]      data_out,
  output logic             data_ready,
  output logic             irq_out
);

  localparam logic [5:0] ADDR_ENABLE  = 6'h00;
  localparam logic [5:0] ADDR_PENDING = 6'h04;
  localparam logic [5:0] ADDR_MODE    = 6'h08;
  localparam logic [5:0] ADDR_CLAIM   = 6'h0C;
  localparam logic [5:0] ADDR_STATUS  = 6'h10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [4:0]       in_service_id, in_service_next;

  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pending, pending_next;
  logic [N_SRC-1:0] irq_prev;

  logic             read_req, write_req;
  logic             claim_rd, claim_wr;
  logic             complete_ok;
  logic             take_claim;
  logic [N_SRC-1:0] wr_mask;
  logic [N_SRC-1:0] wr_bits;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] req;
  logic             cand_valid;
  logic [4:0]       cand_idx;
  logic [4:0]       cand_id;
  logic [31:0]      rd_data;

  // Upper data bits beyond the source count are never stored.
  logic unused_data_bits;
  assign unused_data_bits = ^data_in[31:N_SRC];

  assign read_req  = (data_read_n  != 2'b11);
  assign write_req = (data_write_n != 2'b11);
  assign claim_rd  = read_req  && (address == ADDR_CLAIM);
  assign claim_wr  = write_req && (address == ADDR_CLAIM);

  // 8-bit writes only touch bits [7:0]; wider writes cover every source.
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      wr_mask[i] = (data_write_n != 2'b00) || (i < 8);
    end
  end

  assign wr_bits  = data_in[N_SRC-1:0] & wr_mask;
  assign w1c      = (write_req && (address == ADDR_PENDING)) ? wr_bits : '0;
  assign edge_set = irq_in & ~irq_prev;
  assign req      = pending & enable;

  // Fixed priority: lowest index wins. Uses the registered ENABLE, so a
  // claim coinciding with an ENABLE write arbitrates on the old value.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        cand_valid = 1'b1;
        cand_idx   = 5'(i);
      end
    end
  end

  assign cand_id     = cand_valid ? (cand_idx + 5'd1) : 5'd0;
  assign complete_ok = claim_wr && (data_in[4:0] == in_service_id);

  // FSM state register, together with the in-service ID it tracks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_service_id <= '0;
    end else begin
      state         <= state_next;
      in_service_id <= in_service_next;
    end
  end

  // Next-state logic. A completion write in the same cycle as a CLAIM read
  // wins, so the read then has no side effects.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (claim_rd && !claim_wr && cand_valid) state_next = ACTIVE;
      ACTIVE:  if (complete_ok)                         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: claim side effects and the in-service ID update.
  always_comb begin
    take_claim      = (state == IDLE) && claim_rd && !claim_wr && cand_valid;
    in_service_next = in_service_id;
    claim_clr       = '0;
    if (take_claim) begin
      in_service_next = cand_id;
      for (int i = 0; i < N_SRC; i++) begin
        claim_clr[i] = (cand_idx == 5'(i));
      end
    end else if ((state == ACTIVE) && complete_ok) begin
      in_service_next = '0;
    end
  end

  // Edge sources: a new edge beats any clear in the same cycle.
  // Level sources: follow the input, clears have no effect.
  assign pending_next = (mode & (edge_set | (pending & ~(w1c | claim_clr))))
                      | (~mode & irq_in);

  always_comb begin
    rd_data = '0;
    case (address)
      ADDR_ENABLE:  rd_data = 32'(enable);
      ADDR_PENDING: rd_data = 32'(pending);
      ADDR_MODE:    rd_data = 32'(mode);
      ADDR_CLAIM:   rd_data = 32'((state == ACTIVE) ? in_service_id : cand_id);
      ADDR_STATUS:  rd_data = {23'd0, (state == ACTIVE), 3'd0, in_service_id};
      default:      rd_data = '0;
    endcase
  end

  // Source registers, read port and the registered interrupt output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable     <= '0;
      mode       <= '0;
      pending    <= '0;
      irq_prev   <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      irq_out    <= 1'b0;
    end else begin
      irq_prev <= irq_in;
      pending  <= pending_next;
      if (write_req && (address == ADDR_ENABLE)) begin
        enable <= (enable & ~wr_mask) | wr_bits;
      end
      if (write_req && (address == ADDR_MODE)) begin
        mode <= (mode & ~wr_mask) | wr_bits;
      end
      data_ready <= read_req;
      if (read_req) begin
        data_out <= rd_data;
      end
      irq_out <= (state == IDLE) && (|req);
    end
  end

endmodule
